// File: rtl/mips_pkg.sv
// Shared constants and types for the 16-bit pipelined MIPS datapath.
package mips_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_access_ctrl_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory access.
// last_o is high when the next increment brings the count to MAX_WAIT.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, increment saturates at MAX_WAIT.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_CNT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == LAST_CNT);

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage controller: performs the data-memory load/store over a
// req/ready handshake, stalls the pipeline while an access is in flight,
// resolves branches and presents the MEM/WB-bound data.
module mem_stage_access_ctrl #(
    parameter int unsigned DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned REG_AW   = mips_pkg::REG_AW,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_in,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] branch_target_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_AW-1:0] write_reg_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              pipe_en,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [REG_AW-1:0] write_reg_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic              mem_timeout
);

    import mips_pkg::*;

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              timeout_q, timeout_d;

    logic              access_c;
    logic              timer_clr_c;
    logic              timer_inc_c;
    logic              timer_last_c;

    assign access_c = mem_read_in | mem_write_in;

    // Counts not-ready ACCESS edges; last_o marks the edge that would hit MAX_WAIT.
    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr_c),
        .inc_i  (timer_inc_c),
        .last_o (timer_last_c)
    );

    // Next-state and registered-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        timeout_d   = timeout_q;
        timer_clr_c = 1'b0;
        timer_inc_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access_c) begin
                    addr_d      = alu_result_in;
                    wdata_d     = write_data_in;
                    we_d        = mem_write_in;
                    req_d       = 1'b1;
                    timer_clr_c = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    // Ready beats a simultaneous timeout.
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    timer_inc_c = 1'b1;
                    if (timer_last_c) begin
                        timeout_d = 1'b1;
                        rdata_d   = '0;
                        req_d     = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset also aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_read_data = rdata_q;
    assign mem_timeout   = timeout_q;

    // Stall while a memory instruction is detected or in flight.
    assign pipe_en = ((state_q == IDLE) && !access_c) || (state_q == DONE);

    // Branches resolve only when no access is being processed.
    assign pc_src    = branch_in & zero_in & (state_q == IDLE);
    assign pc_target = branch_target_in;

    assign alu_result_out = alu_result_in;
    assign write_reg_out  = write_reg_in;
    assign reg_write_out  = reg_write_in;
    assign mem_to_reg_out = mem_to_reg_in;

endmodule
